// File: rtl/bus_slot_arbiter_if.sv
// Bus-slot arbiter interface: phase strobes, requester handshake and slot outputs.
// Handshake: a requester raises req and holds it until it sees its done bit
// or abort; gnt marks the slot owner for the whole slot.
interface bus_slot_arbiter_if #(
    parameter int NREQ = 2
);
    logic            enable;
    logic            ba;
    logic            half_m1;
    logic            half_p1;
    logic            full_m2;
    logic            full_m1;
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] gnt;
    logic [NREQ-1:0] done;
    logic            abort;
    logic            bus_oe;
    logic            sample;
    logic            busy;

    // Arbiter side
    modport slave (
        input  enable, ba, half_m1, half_p1, full_m2, full_m1, req,
        output gnt, done, abort, bus_oe, sample, busy
    );

    // Requester / phase-generator side
    modport master (
        output enable, ba, half_m1, half_p1, full_m2, full_m1, req,
        input  gnt, done, abort, bus_oe, sample, busy
    );
endinterface

// File: rtl/bus_slot_arbiter.sv
// Round-robin arbiter for the phi2-high expansion-port bus slot.
// One grant per C64 cycle, issued at half_m1; the slot ends at full_m1
// or is killed by a watchdog when the phase strobes stop arriving.
module bus_slot_arbiter #(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 255
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    bus_slot_arbiter_if.slave    bus
);
    localparam int            RW       = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [7:0]    WD_LIMIT = 8'(TIMEOUT - 1);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [RW-1:0]   r_rr, w_rr_nxt;
    logic [NREQ-1:0] r_gnt, w_gnt_nxt;
    logic [NREQ-1:0] r_done, w_done_nxt;
    logic [7:0]      r_wdog, w_wdog_nxt;
    logic            r_bus_oe, w_bus_oe_nxt;
    logic            r_sample, w_sample_nxt;
    logic            r_abort, w_abort_nxt;
    logic [RW-1:0]   w_winner;
    logic            w_found;

    // Pick the first requester after the last winner, wrapping modulo NREQ
    always_comb begin
        int idx;
        w_winner = '0;
        w_found  = 1'b0;
        idx      = 0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = (int'(r_rr) + i) % NREQ;
            if (!w_found && bus.req[idx]) begin
                w_found  = 1'b1;
                w_winner = RW'(idx);
            end
        end
    end

    // Next-state and next-output logic; full_m1 takes precedence over the watchdog
    always_comb begin
        w_state_nxt  = r_state;
        w_rr_nxt     = r_rr;
        w_gnt_nxt    = r_gnt;
        w_done_nxt   = '0;
        w_wdog_nxt   = r_wdog;
        w_bus_oe_nxt = r_bus_oe;
        w_sample_nxt = 1'b0;
        w_abort_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_gnt_nxt    = '0;
                w_bus_oe_nxt = 1'b0;
                if (bus.half_m1 && bus.enable && bus.ba && w_found) begin
                    w_state_nxt = ST_ACTIVE;
                    w_gnt_nxt   = NREQ'(1) << w_winner;
                    w_rr_nxt    = w_winner;
                    w_wdog_nxt  = 8'd0;
                end
            end
            ST_ACTIVE: begin
                w_wdog_nxt = r_wdog + 8'd1;
                if (bus.half_p1) begin
                    w_bus_oe_nxt = 1'b1;
                end
                if (bus.full_m2 && !bus.full_m1) begin
                    w_sample_nxt = 1'b1;
                end
                if (bus.full_m1) begin
                    w_state_nxt  = ST_IDLE;
                    w_done_nxt   = r_gnt;
                    w_gnt_nxt    = '0;
                    w_bus_oe_nxt = 1'b0;
                    w_wdog_nxt   = 8'd0;
                end else if (r_wdog == WD_LIMIT) begin
                    w_state_nxt  = ST_IDLE;
                    w_abort_nxt  = 1'b1;
                    w_gnt_nxt    = '0;
                    w_bus_oe_nxt = 1'b0;
                    w_sample_nxt = 1'b0;
                    w_wdog_nxt   = 8'd0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset parks rr so requester 0 wins first
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= ST_IDLE;
            r_rr     <= RW'(NREQ - 1);
            r_gnt    <= '0;
            r_done   <= '0;
            r_wdog   <= 8'd0;
            r_bus_oe <= 1'b0;
            r_sample <= 1'b0;
            r_abort  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_rr     <= w_rr_nxt;
            r_gnt    <= w_gnt_nxt;
            r_done   <= w_done_nxt;
            r_wdog   <= w_wdog_nxt;
            r_bus_oe <= w_bus_oe_nxt;
            r_sample <= w_sample_nxt;
            r_abort  <= w_abort_nxt;
        end
    end

    assign bus.gnt    = r_gnt;
    assign bus.done   = r_done;
    assign bus.abort  = r_abort;
    assign bus.bus_oe = r_bus_oe;
    assign bus.sample = r_sample;
    assign bus.busy   = (r_state == ST_ACTIVE);
endmodule

// File: tb/tb_bus_slot_arbiter.sv
// Bench for bus_slot_arbiter: 64-clk C64 cycles with phi2 phase strobes,
// a grant scoreboard fed at half_m1, and a short-TIMEOUT instance for the watchdog.
module tb_bus_slot_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    int   m_rr = 1;
    logic [1:0] exp_q[$];
    logic [1:0] done_q[$];

    bus_slot_arbiter_if #(.NREQ(2)) bif ();
    bus_slot_arbiter_if #(.NREQ(2)) wif ();

    bus_slot_arbiter #(.NREQ(2), .TIMEOUT(255)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bif.slave)
    );

    bus_slot_arbiter #(.NREQ(2), .TIMEOUT(20)) dut_wd (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (wif.slave)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic clear_inputs();
        bif.enable = 1'b0; bif.ba = 1'b0; bif.req = 2'b00;
        bif.half_m1 = 1'b0; bif.half_p1 = 1'b0; bif.full_m2 = 1'b0; bif.full_m1 = 1'b0;
        wif.enable = 1'b0; wif.ba = 1'b0; wif.req = 2'b00;
        wif.half_m1 = 1'b0; wif.half_p1 = 1'b0; wif.full_m2 = 1'b0; wif.full_m1 = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        m_rr = 1;
        exp_q.delete();
        done_q.delete();
    endtask

    // One C64 cycle on bif: phi2 low p=0..31, high p=32..63.
    // Outputs read after edge p reflect the DUT response to phase-p inputs.
    task automatic run_cycle(input logic [1:0] rq, input logic b, input logic e,
                             input logic b_mid, input logic e_mid, output logic [1:0] g_seen);
        logic [1:0] cur_g, e_gnt, e_done;
        logic       e_oe, e_smp, e_busy;
        int         idx;
        bit         found;
        cur_g  = 2'b00;
        g_seen = 2'b00;
        for (int p = 0; p < 64; p++) begin
            bif.req     = rq;
            bif.ba      = (p < 40) ? b : b_mid;
            bif.enable  = (p < 40) ? e : e_mid;
            bif.half_m1 = (p == 31);
            bif.half_p1 = (p == 33);
            bif.full_m2 = (p == 62);
            bif.full_m1 = (p == 63);
            if (p == 31 && e && b && rq != 2'b00) begin
                found = 1'b0;
                for (int k = 1; k <= 2; k++) begin
                    idx = (m_rr + k) % 2;
                    if (!found && rq[idx]) begin
                        found = 1'b1;
                        m_rr  = idx;
                    end
                end
                exp_q.push_back(2'b01 << m_rr);
            end
            @(posedge clk);
            #1;
            if (p == 31) begin
                g_seen = bif.gnt;
                if (exp_q.size() > 0) begin
                    cur_g = exp_q.pop_front();
                    done_q.push_back(cur_g);
                end
            end
            e_gnt  = (p >= 31 && p <= 62) ? cur_g : 2'b00;
            e_busy = (cur_g != 2'b00) && (p >= 31 && p <= 62);
            e_oe   = (cur_g != 2'b00) && (p >= 33 && p <= 62);
            e_smp  = (cur_g != 2'b00) && (p == 62);
            e_done = 2'b00;
            if (p == 63 && cur_g != 2'b00 && done_q.size() > 0) e_done = done_q.pop_front();
            n_checks++;
            if ({bif.gnt, bif.done, bif.abort, bif.bus_oe, bif.sample, bif.busy} !==
                {e_gnt, e_done, 1'b0, e_oe, e_smp, e_busy}) begin
                n_errors++;
                $display("FAIL cycle_p%0d got gnt=%b done=%b abort=%b oe=%b smp=%b busy=%b want gnt=%b done=%b abort=0 oe=%b smp=%b busy=%b",
                         p, bif.gnt, bif.done, bif.abort, bif.bus_oe, bif.sample, bif.busy,
                         e_gnt, e_done, e_oe, e_smp, e_busy);
            end
        end
        bif.half_m1 = 1'b0; bif.half_p1 = 1'b0; bif.full_m2 = 1'b0; bif.full_m1 = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_checks++;
        if ({bif.gnt, bif.done, bif.abort, bif.bus_oe, bif.sample, bif.busy} !== 8'd0) begin
            n_errors++;
            $display("FAIL reset_main got %b want 00000000",
                     {bif.gnt, bif.done, bif.abort, bif.bus_oe, bif.sample, bif.busy});
        end
        n_checks++;
        if ({wif.gnt, wif.done, wif.abort, wif.bus_oe, wif.sample, wif.busy} !== 8'd0) begin
            n_errors++;
            $display("FAIL reset_wd got %b want 00000000",
                     {wif.gnt, wif.done, wif.abort, wif.bus_oe, wif.sample, wif.busy});
        end
    endtask

    task automatic test_single();
        logic [1:0] g;
        run_cycle(2'b01, 1'b1, 1'b1, 1'b1, 1'b1, g);
        n_checks++;
        if (g !== 2'b01) begin
            n_errors++;
            $display("FAIL single_gnt got %b want 01", g);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] g;
        logic [1:0] tbl[4];
        tbl = '{2'b01, 2'b10, 2'b01, 2'b10};
        do_reset();
        for (int c = 0; c < 4; c++) begin
            run_cycle(2'b11, 1'b1, 1'b1, 1'b1, 1'b1, g);
            n_checks++;
            if (g !== tbl[c]) begin
                n_errors++;
                $display("FAIL rr_cycle%0d got %b want %b", c, g, tbl[c]);
            end
        end
    endtask

    task automatic test_ba();
        logic [1:0] g;
        run_cycle(2'b01, 1'b0, 1'b1, 1'b0, 1'b1, g);
        n_checks++;
        if (g !== 2'b00) begin n_errors++; $display("FAIL ba_low_gnt got %b want 00", g); end
        run_cycle(2'b01, 1'b1, 1'b1, 1'b1, 1'b1, g);
        n_checks++;
        if (g !== 2'b01) begin n_errors++; $display("FAIL ba_back_gnt got %b want 01", g); end
        run_cycle(2'b01, 1'b1, 1'b1, 1'b0, 1'b1, g);
    endtask

    task automatic test_enable();
        logic [1:0] g;
        for (int c = 0; c < 3; c++) begin
            run_cycle(2'b01, 1'b1, 1'b0, 1'b1, 1'b0, g);
            n_checks++;
            if (g !== 2'b00) begin n_errors++; $display("FAIL en_off_gnt%0d got %b want 00", c, g); end
        end
        run_cycle(2'b01, 1'b1, 1'b1, 1'b1, 1'b0, g);
        run_cycle(2'b01, 1'b1, 1'b0, 1'b1, 1'b0, g);
        bif.req = 2'b00;
    endtask

    task automatic test_reset_mid();
        logic [1:0] g;
        bif.req = 2'b01; bif.ba = 1'b1; bif.enable = 1'b1;
        for (int p = 0; p < 64; p++) begin
            bif.half_m1 = (p == 31);
            bif.half_p1 = (p == 33);
            bif.full_m2 = (p == 62);
            bif.full_m1 = (p == 63);
            rst = (p == 34);
            @(posedge clk);
            #1;
            if (p == 31) begin
                n_checks++;
                if (bif.gnt !== 2'b01) begin n_errors++; $display("FAIL rstmid_gnt got %b want 01", bif.gnt); end
            end else if (p >= 34) begin
                n_checks++;
                if ({bif.gnt, bif.done, bif.abort, bif.bus_oe, bif.sample, bif.busy} !== 8'd0) begin
                    n_errors++;
                    $display("FAIL rstmid_p%0d got %b want 00000000", p,
                             {bif.gnt, bif.done, bif.abort, bif.bus_oe, bif.sample, bif.busy});
                end
            end
        end
        rst = 1'b0;
        bif.half_m1 = 1'b0; bif.half_p1 = 1'b0; bif.full_m2 = 1'b0; bif.full_m1 = 1'b0;
        m_rr = 1;
        exp_q.delete();
        done_q.delete();
        run_cycle(2'b11, 1'b1, 1'b1, 1'b1, 1'b1, g);
        n_checks++;
        if (g !== 2'b01) begin n_errors++; $display("FAIL rstmid_regrant got %b want 01", g); end
        bif.req = 2'b00;
    endtask

    task automatic test_watchdog();
        int   abort_k;
        logic oe_before;
        abort_k   = -1;
        oe_before = 1'b0;
        wif.req = 2'b01; wif.ba = 1'b1; wif.enable = 1'b1;
        wif.half_m1 = 1'b1;
        @(posedge clk); #1;
        wif.half_m1 = 1'b0;
        n_checks++;
        if (wif.gnt !== 2'b01) begin n_errors++; $display("FAIL wd_gnt got %b want 01", wif.gnt); end
        for (int k = 1; k <= 100; k++) begin
            wif.half_p1 = (k == 1);
            if (k == 20) oe_before = wif.bus_oe;
            @(posedge clk); #1;
            if (wif.abort === 1'b1) begin
                abort_k = k;
                break;
            end
        end
        wif.half_p1 = 1'b0;
        n_checks++;
        if (abort_k != 20) begin n_errors++; $display("FAIL wd_abort_time got %0d want 20", abort_k); end
        n_checks++;
        if ({wif.gnt, wif.done, wif.bus_oe, wif.busy} !== 6'd0) begin
            n_errors++;
            $display("FAIL wd_abort_outs got gnt=%b done=%b oe=%b busy=%b want all 0",
                     wif.gnt, wif.done, wif.bus_oe, wif.busy);
        end
        n_checks++;
        if (oe_before !== 1'b1) begin n_errors++; $display("FAIL wd_oe_before got %b want 1", oe_before); end
        @(posedge clk); #1;
        n_checks++;
        if ({wif.abort, wif.done} !== 3'd0) begin
            n_errors++;
            $display("FAIL wd_after got abort=%b done=%b want 0 00", wif.abort, wif.done);
        end
        wif.req = 2'b00;
    endtask

    task automatic test_wd_tie();
        wif.req = 2'b01; wif.ba = 1'b1; wif.enable = 1'b1;
        wif.half_m1 = 1'b1;
        @(posedge clk); #1;
        wif.half_m1 = 1'b0;
        // rr kept the aborted winner 0, so requester 0 is the only candidate again
        n_checks++;
        if (wif.gnt !== 2'b01) begin n_errors++; $display("FAIL tie_gnt got %b want 01", wif.gnt); end
        repeat (19) @(posedge clk);
        #1 wif.full_m1 = 1'b1;
        @(posedge clk); #1;
        wif.full_m1 = 1'b0;
        n_checks++;
        if ({wif.done, wif.abort, wif.gnt} !== 5'b01_0_00) begin
            n_errors++;
            $display("FAIL tie_end got done=%b abort=%b gnt=%b want 01 0 00", wif.done, wif.abort, wif.gnt);
        end
        @(posedge clk); #1;
        n_checks++;
        if ({wif.done, wif.abort} !== 3'd0) begin
            n_errors++;
            $display("FAIL tie_after got done=%b abort=%b want 00 0", wif.done, wif.abort);
        end
        wif.req = 2'b00;
    endtask

    // Test sequence
    initial begin
        clear_inputs();
        test_reset();
        test_single();
        test_back_to_back();
        test_ba();
        test_enable();
        test_reset_mid();
        test_watchdog();
        test_wd_tie();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
